// File: rtl/i2c_pkg.sv
// Shared types for the byte-level I2C master: FSM states, R/W encodings and bit quarters.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      STOP
   } state_e;

   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

   typedef logic [1:0] quarter_t;

   localparam quarter_t Q0 = 2'd0;
   localparam quarter_t Q1 = 2'd1;
   localparam quarter_t Q2 = 2'd2;
   localparam quarter_t Q3 = 2'd3;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period tick generator: one-cycle pulse every CLK_DIV clocks while enabled.
module i2c_qtick_gen #(
   parameter int CLK_DIV = 250
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);

   localparam int               CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Held at zero while disabled so the first quarter after enable is full length
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!en_i || cnt_q == LAST) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: START, address byte, one data byte (write or read) and STOP.
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_wdata,
   output logic [7:0] rd_data,
   output logic       ack_err,
   output logic       busy,
   output logic       done,
   output logic       scl_o,
   output logic       sda_oe,
   input  logic       sda_i
);

   state_e   state_q, state_d;
   quarter_t q_q;
   logic [2:0] bit_q;
   logic [7:0] shift_q, wdata_q, rd_q;
   logic       rw_q, samp_q, ack_err_q, done_q;
   logic       tick, bit_end, accept;

   i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
      .clk    (clk),
      .rst    (rst),
      .en_i   (state_q != IDLE),
      .tick_o (tick)
   );

   assign accept  = cmd_valid && (state_q == IDLE);
   assign bit_end = tick && (q_q == Q3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = START;
         START:    if (bit_end) state_d = ADDR;
         ADDR:     if (bit_end && bit_q == 3'd7) state_d = ADDR_ACK;
         ADDR_ACK: if (bit_end) state_d = samp_q ? STOP : DATA;
         DATA:     if (bit_end && bit_q == 3'd7) state_d = DATA_ACK;
         DATA_ACK: if (bit_end) state_d = STOP;
         STOP:     if (bit_end) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Shift register serves both directions: MSB drives SDA, the sampled bit enters at the LSB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q       <= Q0;
         bit_q     <= 3'd0;
         shift_q   <= 8'h00;
         wdata_q   <= 8'h00;
         rd_q      <= 8'h00;
         rw_q      <= I2C_WRITE;
         samp_q    <= 1'b0;
         ack_err_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= (state_q == STOP) && bit_end;
         if (accept) begin
            q_q       <= Q0;
            bit_q     <= 3'd0;
            shift_q   <= {cmd_addr, cmd_rw};
            wdata_q   <= cmd_wdata;
            rw_q      <= cmd_rw;
            ack_err_q <= 1'b0;
         end else if (tick) begin
            q_q <= q_q + 2'd1;
            if (q_q == Q2) samp_q <= sda_i;
            if (q_q == Q3) begin
               case (state_q)
                  ADDR, DATA: begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= {shift_q[6:0], samp_q};
                  end
                  ADDR_ACK: begin
                     if (samp_q) ack_err_q <= 1'b1;
                     else        shift_q   <= (rw_q == I2C_READ) ? 8'h00 : wdata_q;
                  end
                  DATA_ACK: begin
                     if (rw_q == I2C_READ) rd_q      <= shift_q;
                     else if (samp_q)      ack_err_q <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // SCL is high in Q2/Q3 of every bit; START and STOP shape their own edges
   always_comb begin
      scl_o  = 1'b1;
      sda_oe = 1'b0;
      case (state_q)
         START: begin
            scl_o  = (q_q != Q3);
            sda_oe = (q_q != Q0);
         end
         ADDR: begin
            scl_o  = q_q[1];
            sda_oe = ~shift_q[7];
         end
         DATA: begin
            scl_o  = q_q[1];
            sda_oe = (rw_q == I2C_WRITE) && !shift_q[7];
         end
         ADDR_ACK, DATA_ACK: scl_o = q_q[1];
         STOP: begin
            scl_o  = (q_q != Q0);
            sda_oe = (q_q == Q0) || (q_q == Q1);
         end
         default: ;
      endcase
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign ack_err   = ack_err_q;
   assign rd_data   = rd_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: directed commands, a small I2C slave model, a scoreboard on done
// and a bus protocol monitor.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;

   localparam int         CLK_DIV  = 4;
   localparam int         T_FULL   = 80 * CLK_DIV;
   localparam int         T_NACK   = 44 * CLK_DIV;
   localparam logic [6:0] SLV_ADDR = 7'h42;

   logic       clk, rst, cmd_valid, cmd_ready, cmd_rw;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_wdata, rd_data;
   logic       ack_err, busy, done, scl_o, sda_oe, sda_i;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_rw    (cmd_rw),
      .cmd_wdata (cmd_wdata),
      .rd_data   (rd_data),
      .ack_err   (ack_err),
      .busy      (busy),
      .done      (done),
      .scl_o     (scl_o),
      .sda_oe    (sda_oe),
      .sda_i     (sda_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // ---------------- slave model (address SLV_ADDR), open-drain bus ----------------
   typedef enum {P_IDLE, P_ADDR, P_WR, P_RD} ph_t;
   ph_t        ph;
   int         bitn;
   logic [7:0] sh, sl_rdbyte;
   logic       sl_drive, pscl, psda;
   logic [8:0] buslog[$];   // {byte seen on bus, ack slot level}

   assign sda_i = ~(sda_oe | sl_drive);

   always @(posedge clk) begin
      if (rst) begin
         ph       <= P_IDLE;
         bitn     <= 0;
         sh       <= 8'h00;
         sl_drive <= 1'b0;
         pscl     <= 1'b1;
         psda     <= 1'b1;
         buslog.delete();
      end else begin
         pscl <= scl_o;
         psda <= sda_i;
         if (pscl && scl_o && psda && !sda_i) begin
            ph <= P_ADDR; bitn <= 0; sl_drive <= 1'b0;
         end else if (pscl && scl_o && !psda && sda_i) begin
            ph <= P_IDLE; sl_drive <= 1'b0;
         end else if (ph != P_IDLE) begin
            if (!pscl && scl_o) begin
               if (bitn < 8)       sh <= {sh[6:0], sda_i};
               else if (bitn == 8) buslog.push_back({sh, sda_i});
               bitn <= bitn + 1;
            end else if (pscl && !scl_o) begin
               if (bitn == 8) begin
                  if (ph == P_ADDR)    sl_drive <= (sh[7:1] == SLV_ADDR);
                  else if (ph == P_WR) sl_drive <= 1'b1;
                  else                 sl_drive <= 1'b0;
               end else if (bitn == 9) begin
                  bitn <= 0;
                  if (ph == P_ADDR && sl_drive) begin
                     if (sh[0]) begin ph <= P_RD; sl_drive <= ~sl_rdbyte[7]; end
                     else begin ph <= P_WR; sl_drive <= 1'b0; end
                  end else begin
                     ph <= P_IDLE; sl_drive <= 1'b0;
                  end
               end else if (ph == P_RD && bitn >= 1 && bitn <= 7) begin
                  sl_drive <= ~sl_rdbyte[7-bitn];
               end
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int         id;
      logic       ack;
      logic [7:0] rd;
      int         lat;
      int         nbytes;
      logic [8:0] b0;
      logic [8:0] b1;
      logic       chk_gap;
   } exp_t;

   exp_t expq[$];
   int   acc_cyc  = 0;
   int   done_cyc = 0;

   function automatic exp_t mk(input int id, input logic ack, input logic [7:0] rd, input int lat,
                               input int nb, input logic [8:0] b0, input logic [8:0] b1,
                               input logic gap);
      exp_t e;
      e.id = id; e.ack = ack; e.rd = rd; e.lat = lat;
      e.nbytes = nb; e.b0 = b0; e.b1 = b1; e.chk_gap = gap;
      return e;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            done_cyc = cyc;
            chk("done_expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
               e = expq.pop_front();
               chk($sformatf("t%0d_ack_err", e.id), ack_err, e.ack);
               chk($sformatf("t%0d_rd_data", e.id), rd_data, e.rd);
               chk($sformatf("t%0d_latency", e.id), cyc - acc_cyc, e.lat);
               chk($sformatf("t%0d_bus_bytes", e.id), buslog.size(), e.nbytes);
               if (buslog.size() > 0) chk($sformatf("t%0d_byte0", e.id), buslog[0], e.b0);
               if (e.nbytes > 1 && buslog.size() > 1)
                  chk($sformatf("t%0d_byte1", e.id), buslog[1], e.b1);
            end
            buslog.delete();
         end
         if (!rst && cmd_valid && cmd_ready) begin
            acc_cyc = cyc + 1;
            if (expq.size() != 0 && expq[0].chk_gap)
               chk($sformatf("t%0d_accept_gap", expq[0].id), acc_cyc - done_cyc, 1);
         end
      end
   end

   // ---------------- protocol monitor ----------------
   logic pm_scl = 1'b1, pm_oe = 1'b0, start_seen, stop_seen, pend;
   int   nfall, nrise, fall_t, rise_t, pend_len;

   task automatic proto_clear();
      start_seen = 1'b0; stop_seen = 1'b0; pend = 1'b0;
      nfall = 0; nrise = 0; fall_t = 0; rise_t = 0; pend_len = 0;
   endtask

   task automatic viol(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: SDA/SCL edge at cycle %0d, required none", nm, cyc);
   endtask

   initial begin : proto
      proto_clear();
      forever begin
         @(negedge clk);
         if (rst) proto_clear();
         else if (done) begin
            chk("proto_start_stop", {start_seen, stop_seen}, 2'b11);
            proto_clear();
         end else if (busy) begin
            if (sda_oe != pm_oe && scl_o && pm_scl) begin
               if (sda_oe && !start_seen && nfall == 0)      start_seen = 1'b1;
               else if (!sda_oe && nfall > 0 && !stop_seen)  stop_seen  = 1'b1;
               else viol("sda_change_scl_high");
            end else if (sda_oe != pm_oe && stop_seen) viol("sda_after_stop");
            if (pm_scl && !scl_o) begin
               if (stop_seen) viol("scl_after_stop");
               if (nrise > 0) chk("scl_high_time", cyc - rise_t, 2 * CLK_DIV);
               if (pend) begin
                  chk("scl_low_time", pend_len, 2 * CLK_DIV);
                  pend = 1'b0;
               end
               fall_t = cyc;
               nfall++;
            end
            if (!pm_scl && scl_o) begin
               pend     = (nrise > 0);
               pend_len = cyc - fall_t;
               rise_t   = cyc;
               nrise++;
            end
         end else proto_clear();
         pm_scl = scl_o;
         pm_oe  = sda_oe;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_accept(input int id);
      int n = 0;
      do begin @(negedge clk); n++; end while (!cmd_ready && n < 2000);
      chk($sformatf("t%0d_cmd_ready", id), cmd_ready, 1);
      @(posedge clk); #1;
   endtask

   task automatic issue(input int id, input logic [6:0] a, input logic rw, input logic [7:0] wd);
      @(posedge clk); #1;
      cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
      wait_accept(id);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_q(input int left);
      int n = 0;
      while (expq.size() > left && n < 4000) begin @(negedge clk); n++; end
      chk("scoreboard_drain", expq.size() > left, 0);
      if (expq.size() > left) expq.delete();
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 7'h00; cmd_rw = 1'b0; cmd_wdata = 8'h00;
      sl_rdbyte = 8'h5A;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ack_err", ack_err, 0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_scl", scl_o, 1);
      chk("rst_sda_oe", sda_oe, 0);
      @(posedge clk); #1 rst = 1'b0;

      // write 0x42 <- 0xA5, both bytes ACKed
      expq.push_back(mk(1, 1'b0, 8'h00, T_FULL, 2, {8'h84, 1'b0}, {8'hA5, 1'b0}, 1'b0));
      issue(1, 7'h42, 1'b0, 8'hA5);
      wait_q(0);

      // read 0x42, slave returns 0x5A, master NACKs
      expq.push_back(mk(2, 1'b0, 8'h5A, T_FULL, 2, {8'h85, 1'b0}, {8'h5A, 1'b1}, 1'b0));
      issue(2, 7'h42, 1'b1, 8'h00);
      wait_q(0);

      // write to absent slave 0x13: address NACK, rd_data held
      expq.push_back(mk(3, 1'b1, 8'h5A, T_NACK, 1, {8'h26, 1'b1}, 9'h000, 1'b0));
      issue(3, 7'h13, 1'b0, 8'hC7);
      wait_q(0);

      // reset during data bit 3 (Q1, SCL low, SDA pulled for a 0 bit)
      issue(9, 7'h42, 1'b0, 8'h0F);
      repeat (212) @(posedge clk);
      #1;
      chk("pre_rst_scl", scl_o, 0);
      chk("pre_rst_sda_oe", sda_oe, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_scl", scl_o, 1);
      chk("mid_rst_sda_oe", sda_oe, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_rd_data", rd_data, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // normal write after reset
      expq.push_back(mk(4, 1'b0, 8'h00, T_FULL, 2, {8'h84, 1'b0}, {8'h3C, 1'b0}, 1'b0));
      issue(4, 7'h42, 1'b0, 8'h3C);
      wait_q(0);

      // cmd_valid held with new values: second command starts the cycle after done
      sl_rdbyte = 8'hC3;
      expq.push_back(mk(5, 1'b0, 8'h00, T_FULL, 2, {8'h84, 1'b0}, {8'h96, 1'b0}, 1'b0));
      expq.push_back(mk(6, 1'b0, 8'hC3, T_FULL, 2, {8'h85, 1'b0}, {8'hC3, 1'b1}, 1'b1));
      @(posedge clk); #1;
      cmd_addr = 7'h42; cmd_rw = 1'b0; cmd_wdata = 8'h96; cmd_valid = 1'b1;
      wait_accept(5);
      cmd_rw = 1'b1; cmd_wdata = 8'h11;
      wait_q(1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_q(0);

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "watchdog");
   end

endmodule
